// File: rtl/rv64g_decode_stage.sv
// RV64G decode stage: one input slot, combinational decode, DEPTH-entry command FIFO; define RV64G_DECODE_STAGE_PERF_EN for perf counters.
// Latency 2 edges from input handshake to valid_o when the FIFO has room.
// Backpressure: ready_o drops only when the slot is occupied and the FIFO is full; ready_i never reaches ready_o.
package rv64g_pkg;
    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_B  = 3'd3,
        FMT_U  = 3'd4,
        FMT_J  = 3'd5,
        FMT_R4 = 3'd6,
        FMT_X  = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rs3;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } decoded_instr_t;
endpackage

// Pure combinational field split plus sign-extended immediate per encoding format.
module rv64g_instr_decoder (
    input  logic [rv64g_pkg::XLEN-1:0] i_pc,
    input  logic [31:0]                i_code,
    output rv64g_pkg::decoded_instr_t  o_dec
);
    import rv64g_pkg::*;

    logic [6:0]      w_op;
    logic [2:0]      w_f3;
    fmt_e            w_fmt;
    logic            w_bad;
    logic [XLEN-1:0] w_imm;

    assign w_op = i_code[6:0];
    assign w_f3 = i_code[14:12];

    always_comb begin
        w_fmt = FMT_X;
        w_bad = 1'b0;
        case (w_op)
            7'b0110111, 7'b0010111: w_fmt = FMT_U;
            7'b1101111:             w_fmt = FMT_J;
            7'b1100111: begin
                w_fmt = FMT_I;
                w_bad = (w_f3 != 3'd0);
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                w_bad = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            7'b0000011: begin
                w_fmt = FMT_I;
                w_bad = (w_f3 == 3'd7);
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                w_bad = w_f3[2];
            end
            7'b0010011, 7'b0011011, 7'b0001111, 7'b1110011, 7'b0000111: w_fmt = FMT_I;
            7'b0110011, 7'b0111011, 7'b0101111, 7'b1010011:             w_fmt = FMT_R;
            7'b0100111:                                                 w_fmt = FMT_S;
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111:             w_fmt = FMT_R4;
            default:                                                    w_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_I:   w_imm = {{(XLEN-12){i_code[31]}}, i_code[31:20]};
            FMT_S:   w_imm = {{(XLEN-12){i_code[31]}}, i_code[31:25], i_code[11:7]};
            FMT_B:   w_imm = {{(XLEN-13){i_code[31]}}, i_code[31], i_code[7], i_code[30:25], i_code[11:8], 1'b0};
            FMT_U:   w_imm = {{(XLEN-32){i_code[31]}}, i_code[31:12], 12'b0};
            FMT_J:   w_imm = {{(XLEN-21){i_code[31]}}, i_code[31], i_code[19:12], i_code[20], i_code[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    always_comb begin
        o_dec         = '0;
        o_dec.pc      = i_pc;
        o_dec.instr   = i_code;
        o_dec.opcode  = w_op;
        o_dec.rd      = i_code[11:7];
        o_dec.rs1     = i_code[19:15];
        o_dec.rs2     = i_code[24:20];
        o_dec.rs3     = i_code[31:27];
        o_dec.funct3  = w_f3;
        o_dec.funct7  = i_code[31:25];
        o_dec.imm     = w_imm;
        o_dec.fmt     = w_fmt;
        o_dec.illegal = w_bad;
    end
endmodule

module rv64g_decode_stage #(
    parameter int  XLEN            = rv64g_pkg::XLEN,
    parameter type decoded_instr_t = rv64g_pkg::decoded_instr_t,
    parameter int  DEPTH           = 2
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [31:0]                code_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output decoded_instr_t             cmd_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [63:0]                instr_cnt_o,
    output logic [63:0]                stall_cnt_o
);
    localparam int            CW      = $clog2(DEPTH+1);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH-1);

    logic                      r_slot_vld;
    logic [XLEN-1:0]           r_slot_pc;
    logic [31:0]               r_slot_code;
    logic [CW-1:0]             r_count;
    logic                      r_vld;
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    decoded_instr_t            r_mem [DEPTH];

    rv64g_pkg::decoded_instr_t w_dec;
    logic                      w_in_hs;
    logic                      w_push;
    logic                      w_pop;
    logic [CW-1:0]             w_count_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    rv64g_instr_decoder u_dec (
        .i_pc   (r_slot_pc),
        .i_code (r_slot_code),
        .o_dec  (w_dec)
    );

    // A pop never frees room for a push in the same cycle: push looks only at the registered count.
    assign ready_o = ~r_slot_vld | (r_count < DEPTH_C);
    assign w_in_hs = valid_i & ready_o;
    assign w_push  = r_slot_vld & (r_count < DEPTH_C);
    assign w_pop   = r_vld & ready_i;
    assign valid_o = r_vld;
    assign count_o = r_count;
    assign cmd_o   = r_mem[r_rptr];

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_slot_vld  <= 1'b0;
            r_slot_pc   <= '0;
            r_slot_code <= '0;
            r_count     <= '0;
            r_vld       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else if (flush_i) begin
            r_slot_vld  <= 1'b0;
            r_count     <= '0;
            r_vld       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
        end else begin
            if (w_in_hs) begin
                r_slot_vld  <= 1'b1;
                r_slot_pc   <= pc_i;
                r_slot_code <= code_i;
            end else if (w_push) begin
                r_slot_vld  <= 1'b0;
            end
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            r_count <= w_count_nxt;
            r_vld   <= (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            r_mem[r_wptr] <= w_dec;
        end
    end

`ifdef RV64G_DECODE_STAGE_PERF_EN
    logic [63:0] r_instr_cnt;
    logic [63:0] r_stall_cnt;

    // Counters observe port-level events, so a flush neither clears nor suppresses them.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_instr_cnt <= r_instr_cnt + 64'd1;
            end
            if (valid_i && !ready_o) begin
                r_stall_cnt <= r_stall_cnt + 64'd1;
            end
        end
    end

    assign instr_cnt_o = r_instr_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    assign instr_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_rv64g_decode_stage.sv
// Bench for rv64g_decode_stage: directed scenarios plus randomized traffic against a queue-level model.
`timescale 1ns/1ps
module tb_rv64g_decode_stage;
    import rv64g_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] code;
    } txn_t;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           flush = 1'b0;
    logic [63:0]    pc = '0;
    logic [31:0]    code = '0;
    logic           vin = 1'b0;
    logic           rdy_out;
    decoded_instr_t cmd;
    logic           vout;
    logic           rdy_in = 1'b0;
    logic [1:0]     count;
    logic [63:0]    icnt;
    logic [63:0]    scnt;

    rv64g_decode_stage #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .flush_i     (flush),
        .pc_i        (pc),
        .code_i      (code),
        .valid_i     (vin),
        .ready_o     (rdy_out),
        .cmd_o       (cmd),
        .valid_o     (vout),
        .ready_i     (rdy_in),
        .count_o     (count),
        .instr_cnt_o (icnt),
        .stall_cnt_o (scnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    txn_t        m_q[$];
    txn_t        m_slot;
    bit          m_slot_vld = 1'b0;
    bit          last_hs = 1'b0;
    logic [63:0] seen[$];

    logic [31:0] t_code[8];
    logic [63:0] t_imm[8];
    fmt_e        t_fmt[8];
    logic [4:0]  t_rd[8];
    logic [4:0]  t_rs1[8];
    logic        t_ill[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return !m_slot_vld || (m_q.size() < DEPTH);
    endfunction

    task automatic compare();
        check("count", 64'(count), 64'(m_q.size()));
        check("valid", 64'(vout), 64'(m_q.size() != 0));
        check("ready", 64'(rdy_out), 64'(m_ready()));
        if (m_q.size() != 0) begin
            check("head_pc", cmd.pc, m_q[0].pc);
            check("head_code", 64'(cmd.instr), 64'(m_q[0].code));
        end
    endtask

    // Advance one clock: predict from pre-edge state, update the model, then compare 1ns after the edge.
    task automatic cycle();
        bit   hs;
        bit   push;
        bit   pop;
        txn_t t;
        hs   = vin && m_ready();
        push = m_slot_vld && (m_q.size() < DEPTH);
        pop  = (m_q.size() != 0) && rdy_in;
        if (vout && rdy_in) seen.push_back(cmd.pc);
        @(posedge clk);
        if (flush) begin
            m_q.delete();
            m_slot_vld = 1'b0;
        end else begin
            if (pop) t = m_q.pop_front();
            if (push) m_q.push_back(m_slot);
            if (hs) begin
                m_slot.pc   = pc;
                m_slot.code = code;
                m_slot_vld  = 1'b1;
            end else if (push) begin
                m_slot_vld = 1'b0;
            end
        end
        last_hs = hs && !flush;
        #1;
        compare();
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        vin    = 1'b0;
        flush  = 1'b0;
        rdy_in = 1'b0;
        #2;
        check("rst_async_count", 64'(count), 64'd0);
        check("rst_async_valid", 64'(vout), 64'd0);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        m_q.delete();
        m_slot_vld = 1'b0;
        seen.delete();
        @(posedge clk);
        #1;
        check("rst_valid", 64'(vout), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_ready", 64'(rdy_out), 64'd1);
        check("rst_cmd_zero", 64'(cmd == '0), 64'd1);
        check("rst_icnt", icnt, 64'd0);
        check("rst_scnt", scnt, 64'd0);
    endtask

    // Streams pc 0x0, 0x4, 0x8 with ready_i low: leaves count 2, slot holding 0x8, 0xC offered.
    task automatic fill_full();
        rdy_in = 1'b0;
        vin    = 1'b1;
        pc     = 64'h0;
        code   = $urandom;
        repeat (3) begin
            cycle();
            if (last_hs) begin
                pc   = pc + 64'd4;
                code = $urandom;
            end
        end
    endtask

    initial begin
        logic [63:0] exp_i;
        logic [63:0] exp_s;
        int          k;

        t_code[0] = 32'h0000_0013; t_imm[0] = 64'h0;                   t_fmt[0] = FMT_I; t_rd[0] = 5'd0; t_rs1[0] = 5'd0; t_ill[0] = 1'b0;
        t_code[1] = 32'h1234_52B7; t_imm[1] = 64'h0000_0000_1234_5000; t_fmt[1] = FMT_U; t_rd[1] = 5'd5; t_rs1[1] = 5'd8; t_ill[1] = 1'b0;
        t_code[2] = 32'hFFF1_0093; t_imm[2] = 64'hFFFF_FFFF_FFFF_FFFF; t_fmt[2] = FMT_I; t_rd[2] = 5'd1; t_rs1[2] = 5'd2; t_ill[2] = 1'b0;
        t_code[3] = 32'h0032_2423; t_imm[3] = 64'h8;                   t_fmt[3] = FMT_S; t_rd[3] = 5'd8; t_rs1[3] = 5'd4; t_ill[3] = 1'b0;
        t_code[4] = 32'hFE00_0EE3; t_imm[4] = 64'hFFFF_FFFF_FFFF_FFFC; t_fmt[4] = FMT_B; t_rd[4] = 5'd29; t_rs1[4] = 5'd0; t_ill[4] = 1'b0;
        t_code[5] = 32'h0010_00EF; t_imm[5] = 64'h800;                 t_fmt[5] = FMT_J; t_rd[5] = 5'd1; t_rs1[5] = 5'd0; t_ill[5] = 1'b0;
        t_code[6] = 32'h0000_0000; t_imm[6] = 64'h0;                   t_fmt[6] = FMT_X; t_rd[6] = 5'd0; t_rs1[6] = 5'd0; t_ill[6] = 1'b1;
        t_code[7] = 32'h0020_81B3; t_imm[7] = 64'h0;                   t_fmt[7] = FMT_R; t_rd[7] = 5'd3; t_rs1[7] = 5'd1; t_ill[7] = 1'b0;

        do_reset();

        // Single addi x0,x0,0 with downstream always ready.
        rdy_in = 1'b1;
        vin    = 1'b1;
        pc     = 64'h8000_0000;
        code   = 32'h0000_0013;
        cycle();
        vin = 1'b0;
        check("single_edge1_valid", 64'(vout), 64'd0);
        cycle();
        check("single_edge2_valid", 64'(vout), 64'd1);
        check("single_pc", cmd.pc, 64'h8000_0000);
        check("single_code", 64'(cmd.instr), 64'h13);
        check("single_opcode", 64'(cmd.opcode), 64'h13);
        check("single_fmt", 64'(cmd.fmt), 64'(FMT_I));
        check("single_imm", cmd.imm, 64'h0);
        cycle();
        check("single_edge3_valid", 64'(vout), 64'd0);

        // Decode table streamed back to back, one result per cycle.
        k = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                vin  = 1'b1;
                pc   = 64'h1000 + 64'(4 * i);
                code = t_code[i];
            end else begin
                vin = 1'b0;
            end
            cycle();
            if (vout && k < 8) begin
                check("dec_imm", cmd.imm, t_imm[k]);
                check("dec_fmt", 64'(cmd.fmt), 64'(t_fmt[k]));
                check("dec_rd", 64'(cmd.rd), 64'(t_rd[k]));
                check("dec_rs1", 64'(cmd.rs1), 64'(t_rs1[k]));
                check("dec_illegal", 64'(cmd.illegal), 64'(t_ill[k]));
                k++;
            end
        end
        check("dec_all_seen", 64'(k), 64'd8);

        // Backpressure then drain in order.
        do_reset();
        fill_full();
        check("bp_count_full", 64'(count), 64'd2);
        check("bp_ready_low", 64'(rdy_out), 64'd0);
        seen.delete();
        rdy_in = 1'b1;
        repeat (8) begin
            cycle();
            if (last_hs) vin = 1'b0;
        end
        check("bp_seen_n", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            check("bp_order", seen[i], 64'(4 * i));
        end

        // Full FIFO with a pop: no push that edge, refill next edge.
        do_reset();
        fill_full();
        vin    = 1'b0;
        rdy_in = 1'b1;
        cycle();
        check("fullpop_count1", 64'(count), 64'd1);
        rdy_in = 1'b0;
        cycle();
        check("fullpop_count2", 64'(count), 64'd2);

        // Flush with a concurrent offer of pc 0x100.
        do_reset();
        fill_full();
        flush = 1'b1;
        pc    = 64'h100;
        cycle();
        check("flush_valid", 64'(vout), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        flush = 1'b0;
        vin   = 1'b0;
        seen.delete();
        rdy_in = 1'b1;
        repeat (5) cycle();
        check("flush_nothing_out", 64'(seen.size()), 64'd0);

        // Performance counters: 5 stall cycles then 3 output handshakes.
        do_reset();
        fill_full();
        repeat (5) cycle();
        vin    = 1'b0;
        rdy_in = 1'b1;
        repeat (3) cycle();
        rdy_in = 1'b0;
        cycle();
`ifdef RV64G_DECODE_STAGE_PERF_EN
        exp_i = 64'd3;
        exp_s = 64'd5;
`else
        exp_i = 64'd0;
        exp_s = 64'd0;
`endif
        check("perf_instr_cnt", icnt, exp_i);
        check("perf_stall_cnt", scnt, exp_s);

        // Randomized traffic with occasional flush and one reset mid-stream.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            vin    = ($urandom_range(0, 3) != 0);
            rdy_in = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 59) == 0);
            pc     = {$urandom, $urandom} & ~64'h3;
            code   = $urandom;
            cycle();
        end
        flush = 1'b0;
        vin   = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
